// File: rtl/ee354_press_decoder_if.sv
// Button-event handshake bundle for ee354_press_decoder.
//   DPB, SCEN, MCEN : debounced level and single-cycle pulses from ee354_debouncer
//   EVT_ACK         : consumer acknowledge of the current event
//   EVT_VALID       : event register holds an unconsumed event
//   EVT_CODE        : 00 TAP, 01 DTAP, 10 HOLD, 11 RPT
//   OVR             : sticky overrun, an event was dropped
//   EVT_CNT         : events loaded into the event register, wraps 255->0
// slave  : decoder side (consumes button inputs and ack, drives events)
// master : source/consumer side
interface ee354_press_decoder_if;
  logic       DPB;
  logic       SCEN;
  logic       MCEN;
  logic       EVT_ACK;
  logic       EVT_VALID;
  logic [1:0] EVT_CODE;
  logic       OVR;
  logic [7:0] EVT_CNT;

  modport slave (
    input  DPB, SCEN, MCEN, EVT_ACK,
    output EVT_VALID, EVT_CODE, OVR, EVT_CNT
  );

  modport master (
    output DPB, SCEN, MCEN, EVT_ACK,
    input  EVT_VALID, EVT_CODE, OVR, EVT_CNT
  );
endinterface

// File: rtl/ee354_press_decoder.sv
// Press decoder: turns debounced button pulses into TAP / DTAP / HOLD / RPT
// events held in a single-entry event register with acknowledge and a
// sticky overrun flag.
//   CLK    : system clock, all state updates on the rising edge
//   RESET  : synchronous active-high reset
//   bus    : ee354_press_decoder_if.slave (button inputs, ack, event outputs)
// Parameters:
//   DT_WIN : double-tap window length in CLK cycles (2 .. 2^26-1)
//   CW     : window counter width, DT_WIN-1 must fit
module ee354_press_decoder #(
  parameter int unsigned DT_WIN = 25_000_000,
  parameter int unsigned CW     = 26
) (
  input  logic                   CLK,
  input  logic                   RESET,
  ee354_press_decoder_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_HELD,
    S_WREL
  } state_t;

  typedef enum logic [1:0] {
    EV_TAP  = 2'b00,
    EV_DTAP = 2'b01,
    EV_HOLD = 2'b10,
    EV_RPT  = 2'b11
  } evt_t;

  localparam logic [CW-1:0] WIN_LAST = CW'(DT_WIN - 1);

  state_t        r_state;
  logic [CW-1:0] r_win;
  evt_t          r_code;
  logic          r_valid;
  logic          r_ovr;
  logic [7:0]    r_cnt;

  logic          w_raise;
  evt_t          w_code;

  // Event raised by the current state and inputs; registered below so it
  // appears on the edge that ends the triggering cycle. SCEN is tested
  // before the timeout so a tap on the last window cycle is a DTAP only.
  always_comb begin
    w_raise = 1'b0;
    w_code  = EV_TAP;
    case (r_state)
      S_PRESS1: begin
        if (bus.MCEN) begin
          w_raise = 1'b1;
          w_code  = EV_HOLD;
        end
      end
      S_GAP: begin
        if (bus.SCEN) begin
          w_raise = 1'b1;
          w_code  = EV_DTAP;
        end else if (r_win == WIN_LAST) begin
          w_raise = 1'b1;
          w_code  = EV_TAP;
        end
      end
      S_HELD: begin
        if (bus.MCEN) begin
          w_raise = 1'b1;
          w_code  = EV_RPT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_code  <= EV_TAP;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.SCEN) r_state <= S_PRESS1;
        end
        S_PRESS1: begin
          if (bus.MCEN) begin
            r_state <= S_HELD;
          end else if (!bus.DPB) begin
            r_win   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (bus.SCEN) begin
            r_state <= S_WREL;
          end else if (r_win == WIN_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_win <= r_win + 1'b1;
          end
        end
        S_HELD: begin
          if (!bus.DPB) r_state <= S_IDLE;
        end
        S_WREL: begin
          if (!bus.DPB) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A same-cycle ack frees the register for the incoming event.
      if (w_raise) begin
        if (!r_valid || bus.EVT_ACK) begin
          r_code  <= w_code;
          r_valid <= 1'b1;
          r_cnt   <= r_cnt + 8'd1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (bus.EVT_ACK) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.EVT_VALID = r_valid;
  assign bus.EVT_CODE  = r_code;
  assign bus.OVR       = r_ovr;
  assign bus.EVT_CNT   = r_cnt;

endmodule

// File: tb/tb_ee354_press_decoder.sv
module tb_ee354_press_decoder;

  localparam int DT_WIN = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ee354_press_decoder_if bus ();

  ee354_press_decoder #(
    .DT_WIN (DT_WIN),
    .CW     (4)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: press phase flags plus an age counter for the
  // double-tap window, and the consumer-visible event register.
  bit m_armed;     // first press seen, waiting for release or hold
  int m_gap_age;   // cycles spent waiting for a second tap, -1 when not waiting
  bit m_holding;
  bit m_wait_rel;
  bit m_valid;
  int m_code;
  bit m_ovr;
  int m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clock(input bit dpb, input bit scen, input bit mcen, input bit ack, input bit r);
    bit raise;
    int code;
    raise = 0;
    code  = 0;
    if (r) begin
      m_armed = 0; m_gap_age = -1; m_holding = 0; m_wait_rel = 0;
      m_valid = 0; m_code = 0; m_ovr = 0; m_cnt = 0;
      return;
    end
    if (m_armed) begin
      if (mcen) begin
        raise = 1; code = 2; m_armed = 0; m_holding = 1;
      end else if (!dpb) begin
        m_armed = 0; m_gap_age = 0;
      end
    end else if (m_gap_age >= 0) begin
      if (scen) begin
        raise = 1; code = 1; m_gap_age = -1; m_wait_rel = 1;
      end else if (m_gap_age == DT_WIN - 1) begin
        raise = 1; code = 0; m_gap_age = -1;
      end else begin
        m_gap_age++;
      end
    end else if (m_holding) begin
      if (mcen) begin
        raise = 1; code = 3;
      end
      if (!dpb) m_holding = 0;
    end else if (m_wait_rel) begin
      if (!dpb) m_wait_rel = 0;
    end else if (scen) begin
      m_armed = 1;
    end

    if (raise) begin
      if (!m_valid || ack) begin
        m_code  = code;
        m_valid = 1;
        m_cnt   = (m_cnt + 1) % 256;
      end else begin
        m_ovr = 1;
      end
    end else if (ack) begin
      m_valid = 0;
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, compare all outputs 1ns later.
  task automatic step(input bit dpb, input bit scen, input bit mcen, input bit ack, input bit r);
    @(negedge clk);
    bus.DPB     = dpb;
    bus.SCEN    = scen;
    bus.MCEN    = mcen;
    bus.EVT_ACK = ack;
    rst         = r;
    @(posedge clk);
    model_clock(dpb, scen, mcen, ack, r);
    #1;
    check_eq("valid", 32'(bus.EVT_VALID), 32'(m_valid));
    check_eq("code",  32'(bus.EVT_CODE),  32'(m_code));
    check_eq("ovr",   32'(bus.OVR),       32'(m_ovr));
    check_eq("cnt",   32'(bus.EVT_CNT),   32'(m_cnt));
  endtask

  task automatic idle_n(input int n, input bit dpb);
    for (int i = 0; i < n; i++) step(dpb, 0, 0, 0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.DPB = 0; bus.SCEN = 0; bus.MCEN = 0; bus.EVT_ACK = 0;
    rst = 1;
    m_gap_age = -1;

    // Reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_eq("rst_valid", 32'(bus.EVT_VALID), 32'd0);
    check_eq("rst_cnt",   32'(bus.EVT_CNT),   32'd0);

    // Single tap: TAP exactly DT_WIN cycles after entering the gap
    step(1, 1, 0, 0, 0);
    idle_n(2, 1);
    step(0, 0, 0, 0, 0);            // release: gap entry at this edge
    idle_n(DT_WIN - 1, 0);
    check_eq("tap_early", 32'(bus.EVT_VALID), 32'd0);
    step(0, 0, 0, 0, 0);
    check_eq("tap_valid", 32'(bus.EVT_VALID), 32'd1);
    check_eq("tap_code",  32'(bus.EVT_CODE),  32'd0);
    check_eq("tap_cnt",   32'(bus.EVT_CNT),   32'd1);
    step(0, 0, 0, 1, 0);
    check_eq("ack_clear", 32'(bus.EVT_VALID), 32'd0);
    check_eq("code_hold", 32'(bus.EVT_CODE),  32'd0);

    // Double tap mid-window
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle_n(3, 0);
    step(1, 1, 0, 0, 0);
    check_eq("dtap_code", 32'(bus.EVT_CODE), 32'd1);
    check_eq("dtap_cnt",  32'(bus.EVT_CNT),  32'd2);
    step(0, 0, 0, 1, 0);
    idle_n(DT_WIN + 2, 0);
    check_eq("no_tap_after_dtap", 32'(bus.EVT_CNT), 32'd2);

    // Second tap on the timeout cycle: DTAP only
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle_n(DT_WIN - 1, 0);
    step(1, 1, 0, 0, 0);
    check_eq("edge_code", 32'(bus.EVT_CODE), 32'd1);
    check_eq("edge_cnt",  32'(bus.EVT_CNT),  32'd3);
    step(0, 0, 0, 1, 0);

    // Hold then repeats, acked each time
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    check_eq("hold_code", 32'(bus.EVT_CODE), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 1, 0);
      check_eq("rpt_code", 32'(bus.EVT_CODE), 32'd3);
    end
    check_eq("rpt_cnt", 32'(bus.EVT_CNT), 32'd7);
    step(0, 0, 0, 1, 0);

    // Overrun: unacked HOLD then MCEN, then ack coincident with MCEN
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    check_eq("ovr_code", 32'(bus.EVT_CODE), 32'd2);
    check_eq("ovr_flag", 32'(bus.OVR),      32'd1);
    check_eq("ovr_cnt",  32'(bus.EVT_CNT),  32'd8);
    step(1, 0, 1, 1, 0);
    check_eq("ack_mcen_code",  32'(bus.EVT_CODE),  32'd3);
    check_eq("ack_mcen_valid", 32'(bus.EVT_VALID), 32'd1);
    step(0, 0, 0, 0, 0);
    check_eq("ovr_sticky", 32'(bus.OVR), 32'd1);

    // Reset mid-window with valid and overrun set, then held DPB without SCEN
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle_n(3, 0);
    step(1, 1, 0, 1, 1);
    check_eq("midrst_valid", 32'(bus.EVT_VALID), 32'd0);
    check_eq("midrst_ovr",   32'(bus.OVR),       32'd0);
    check_eq("midrst_code",  32'(bus.EVT_CODE),  32'd0);
    idle_n(DT_WIN + 4, 1);
    idle_n(DT_WIN + 4, 0);
    check_eq("midrst_no_tap", 32'(bus.EVT_CNT), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 5) == 0,
           ($urandom % 3) == 0, ($urandom % 250) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
